// File: rtl/mc_pkg.sv
// mc_pkg: state, opcode, funct and ALU encodings shared by the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE,
    ALUWB, BRANCH, IMMEXEC, IMMWB, JUMP, HALT
  } statetype;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ORI   = 6'b001101;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  function automatic statetype decode_op(input logic [5:0] op);
    return (op == LW || op == SW) ? MEMADR :
           op == RTYPE ? EXECUTE :
           (op == BEQ || op == BNE) ? BRANCH :
           (op == ADDI || op == ORI) ? IMMEXEC :
           op == J ? JUMP : HALT;
  endfunction
endpackage

// File: rtl/mc_if.sv
// mc_if: controller <-> datapath bundle; master = controller (drives controls), slave = datapath
interface mc_if;
  import mc_pkg::*;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       halted;
  logic [3:0] state_o;
  modport master (
    input  op, funct, zero, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, zeroext, alucontrol, pcsrc, pcen, halted, state_o
  );
  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, zeroext, alucontrol, pcsrc, pcen, halted, state_o
  );
endinterface

// File: rtl/mc_aludec.sv
// mc_aludec: R-type funct -> alucontrol (in: funct[6]; out: alucontrol[3], x for unlisted funct)
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  always_comb
    alucontrol = funct == F_ADD ? ALU_ADD :
                 funct == F_SUB ? ALU_SUB :
                 funct == F_AND ? ALU_AND :
                 funct == F_OR  ? ALU_OR  :
                 funct == F_SLT ? ALU_SLT : 3'bxxx;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM (clk, async active-low reset, mc_if.master m)
module mc_controller
  import mc_pkg::*;
(
  input logic   clk,
  input logic   reset,
  mc_if.master  m
);
  statetype   state, state_nx;
  logic [2:0] funct_alu;
  mc_aludec u_aludec (.funct(m.funct), .alucontrol(funct_alu));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:    state_nx = m.mem_ready ? DECODE : FETCH;
      DECODE:   state_nx = decode_op(m.op);
      MEMADR:   state_nx = m.op == SW ? MEMWRITE : MEMREAD;
      MEMREAD:  state_nx = m.mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: state_nx = m.mem_ready ? FETCH : MEMWRITE;
      EXECUTE:  state_nx = ALUWB;
      IMMEXEC:  state_nx = IMMWB;
      HALT:     state_nx = HALT;
      default:  state_nx = FETCH;
    endcase
    m.iord       = state == MEMREAD || state == MEMWRITE;
    m.memwrite   = reset && state == MEMWRITE;
    m.irwrite    = reset && state == FETCH && m.mem_ready;
    m.regdst     = state == ALUWB;
    m.memtoreg   = state == MEMWB;
    m.regwrite   = reset && (state == MEMWB || state == ALUWB || state == IMMWB);
    m.alusrca    = state inside {MEMADR, EXECUTE, BRANCH, IMMEXEC};
    m.alusrcb    = state == FETCH ? 2'b01 :
                   state == DECODE ? 2'b11 :
                   state inside {MEMADR, IMMEXEC} ? 2'b10 : 2'b00;
    // op is the instruction register, so IMMWB can still see ori without extra storage
    m.zeroext    = state inside {IMMEXEC, IMMWB} && m.op == ORI;
    m.alucontrol = state inside {FETCH, DECODE, MEMADR} ? ALU_ADD :
                   state == EXECUTE ? funct_alu :
                   state == BRANCH ? ALU_SUB :
                   state == IMMEXEC ? (m.op == ORI ? ALU_OR : ALU_ADD) : 3'b000;
    m.pcsrc      = state == BRANCH ? 2'b01 : state == JUMP ? 2'b10 : 2'b00;
    m.pcen       = reset && ((state == FETCH && m.mem_ready) ||
                             (state == BRANCH && (m.op == BNE ? !m.zero : m.zero)) ||
                             state == JUMP);
    m.halted     = state == HALT;
    m.state_o    = state;
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction stream checked against a phase-list reference model
module tb_mc_controller;
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, EX = 6;
  localparam int AWB = 7, BR = 8, IE = 9, IWB = 10, JP = 11, H = 12;
  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen, halted;
    logic [3:0] state_o;
  } ctl_t;
  logic clk = 0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   seq[$];
  int   idx;
  int   hold;
  logic [5:0] legal_ops [8] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h02};
  logic [5:0] bad_ops   [3] = '{6'h3f, 6'h01, 6'h10};
  logic [5:0] functs    [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  mc_if m ();
  mc_controller dut (.clk(clk), .reset(reset), .m(m));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic void build(input logic [5:0] o);
    case (o)
      6'h23:        seq = {F, D, MA, MR, MWB};
      6'h2b:        seq = {F, D, MA, MW};
      6'h00:        seq = {F, D, EX, AWB};
      6'h04, 6'h05: seq = {F, D, BR};
      6'h08, 6'h0d: seq = {F, D, IE, IWB};
      6'h02:        seq = {F, D, JP};
      default:      seq = {F, D, H};
    endcase
  endfunction
  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      default: return 3'b111;
    endcase
  endfunction
  function automatic ctl_t expect_ctl(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                      input logic z, input logic mr, input logic rst);
    ctl_t c = '0;
    c.state_o = ph[3:0];
    case (ph)
      F:   begin c.alusrcb = 2'b01; c.alucontrol = 3'b010; c.irwrite = mr; c.pcen = mr; end
      D:   begin c.alusrcb = 2'b11; c.alucontrol = 3'b010; end
      MA:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
      MR:  c.iord = 1;
      MWB: begin c.memtoreg = 1; c.regwrite = 1; end
      MW:  begin c.iord = 1; c.memwrite = 1; end
      EX:  begin c.alusrca = 1; c.alucontrol = alu_of(fn); end
      AWB: begin c.regdst = 1; c.regwrite = 1; end
      BR:  begin c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = op == 6'h04 ? z : !z; end
      IE:  begin
             c.alusrca = 1; c.alusrcb = 2'b10;
             c.alucontrol = op == 6'h0d ? 3'b001 : 3'b010;
             c.zeroext = op == 6'h0d;
           end
      IWB: begin c.regwrite = 1; c.zeroext = op == 6'h0d; end
      JP:  begin c.pcsrc = 2'b10; c.pcen = 1; end
      H:   c.halted = 1;
      default: ;
    endcase
    if (!rst) begin c.irwrite = 0; c.pcen = 0; c.regwrite = 0; c.memwrite = 0; end
    return c;
  endfunction
  task automatic cycle(input logic rst_v, input int mr_v);
    int   ph;
    ctl_t got;
    reset = rst_v;
    if (!rst_v) begin seq = {F}; idx = 0; hold = 0; end
    ph = seq[idx];
    if (ph == F) begin
      m.op = $urandom_range(0, 19) == 0 ? bad_ops[$urandom_range(0, 2)] : legal_ops[$urandom_range(0, 7)];
      m.funct = m.op == 6'h00 ? functs[$urandom_range(0, 4)] : 6'($urandom);
    end
    if (ph == H) hold++;
    m.zero = 1'($urandom_range(0, 1));
    m.mem_ready = mr_v >= 0 ? 1'(mr_v) : $urandom_range(0, 9) < 7;
    #3;
    got = {m.iord, m.memwrite, m.irwrite, m.regdst, m.memtoreg, m.regwrite, m.alusrca,
           m.alusrcb, m.zeroext, m.alucontrol, m.pcsrc, m.pcen, m.halted, m.state_o};
    chk($sformatf("ph%0d_op%h", ph, m.op), 32'(got),
        32'(expect_ctl(ph, m.op, m.funct, m.zero, m.mem_ready, rst_v)));
    if (rst_v && ph != H && !((ph == F || ph == MR || ph == MW) && !m.mem_ready)) begin
      if (ph == F) begin build(m.op); idx = 1; end
      else begin
        idx++;
        if (idx == seq.size()) begin seq = {F}; idx = 0; end
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 0;
    m.op = 6'h00;
    m.funct = 6'h20;
    m.zero = 0;
    m.mem_ready = 1;
    seq = {F};
    idx = 0;
    hold = 0;
    repeat (3) cycle(1'b0, 1);
    cycle(1'b1, 1);
    repeat (4000) cycle(!(hold >= 10 || $urandom_range(0, 199) == 0), -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS core, sequencing a shared-memory multicycle datapath: one ALU, one unified instruction/data memory, an instruction register and a PC enable. It decodes opcode/funct from the instruction register and drives per-state datapath selects and write enables. It waits on a memory ready handshake for every memory access. An illegal opcode traps into a sticky halt. Instruction set: lw, sw, R-type (add, sub, and, or, slt), beq, bne, addi, ori, j.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  6  opcode, from IR[31:26]
- funct  in  6  function field, from IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes on this edge
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write request
- irwrite  out  1  instruction register load
- regdst  out  1  write-register select: 0 = rt, 1 = rd
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = Data
- regwrite  out  1  register file write
- alusrca  out  1  ALU A select: 0 = PC, 1 = A register
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- zeroext  out  1  immediate zero-extend (ori); otherwise sign-extend
- alucontrol  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- pcsrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC register enable
- halted  out  1  sticky illegal-opcode trap
- state_o  out  4  current state, for debug

## Operation
- The state register is the only storage. All outputs are Moore decodes of the state, except three combinational paths: pcen uses zero and mem_ready, irwrite uses mem_ready, and alucontrol uses funct in EXECUTE.
- Each state names its settings; every control not listed is 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite = pcen = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: alusrca=0, alusrcb=11, add (precomputes the branch target).
  - Next state by op: lw/sw→MEMADR, R-type→EXECUTE, beq/bne→BRANCH, addi/ori→IMMEXEC, j→JUMP, anything else→HALT.
- MEMADR: alusrca=1, alusrcb=10, add. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Go to FETCH.
- MEMWRITE: iord=1, memwrite=1. Hold until mem_ready=1, then go to FETCH.
- EXECUTE: alusrca=1, alusrcb=00. alucontrol comes from funct; an unlisted funct drives 3'bxxx. Go to ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero for beq, ~zero for bne. Go to FETCH.
- IMMEXEC: alusrca=1, alusrcb=10.
  - addi: add, zeroext=0.
  - ori: or, zeroext=1.
  - Go to IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1. zeroext holds its IMMEXEC value. Go to FETCH.
- JUMP: pcsrc=10, pcen=1. Go to FETCH.
- HALT: no enables. halted=1. Remains until reset.

## Timing
- Reset:
  - reset low asynchronously forces state=FETCH.
  - While reset is low, irwrite, pcen, regwrite and memwrite are forced to 0. halted=0, state_o=0.
  - The first fetch completes on the first edge with reset high and mem_ready=1.
- Cycles per instruction with mem_ready tied high:
  - lw: 5
  - sw, R-type, addi, ori: 4
  - beq, bne, j: 3
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs are held constant during the stall.
- memwrite stays asserted for the whole MEMWRITE stay. The memory commits exactly once, on the edge where mem_ready=1.
- Reset asserted mid-instruction, including during a stall, abandons the instruction; no enable pulses after reset falls.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

## Structure
- Package mc_pkg holds:
  - typedef enum logic [3:0] statetype, with FETCH=0 and codes in the order listed above.
  - opcode localparams: RTYPE, LW, SW, BEQ, BNE, ADDI, ORI, J.
  - ALU function localparams.
- One sub-module, mc_aludec: combinational funct→alucontrol decode for EXECUTE.
- The state register and next-state/output decode stay in mc_controller.

## Test plan
- Reset held low for 3 cycles with mem_ready=1 → state_o=0, all enables 0. After release, irwrite=pcen=1 in cycle 1 and state_o=DECODE in cycle 2.
- op=100011 (lw), mem_ready=1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regwrite=1 and memtoreg=1 only in MEMWB.
- op=101011 (sw), mem_ready low for 2 cycles in MEMWRITE → memwrite high for 3 cycles, returns to FETCH after the 3rd, regwrite never asserted.
- op=000101 (bne):
  - zero=0 → pcen=1, pcsrc=01 in BRANCH.
  - zero=1 → pcen=0.
  - Repeat with op=000100 (beq) and expect the opposite results.
- op=001101 (ori) → alucontrol=001 and zeroext=1 in IMMEXEC, regwrite=1 in IMMWB. op=000000 with funct=101010 → alucontrol=111 in EXECUTE.
- op=111111 → HALT, halted=1 and no enables for 10 cycles. reset low, then high → halted=0, fetch resumes.
